// File: rtl/sargantana_icache_refill_unit.sv
// rtl/sargantana_icache_refill_unit.sv - icache line refill engine with invalidation forwarding and replay
//
// Accepts one line-fill request from the icache, issues a single line-aligned
// memory read, assembles N_BEAT return beats into a full line and hands it back
// with a one-cycle valid pulse. External invalidations are forwarded one cycle
// later. An invalidation that hits the line being filled poisons the fill; the
// fill still completes, and the latched index is re-invalidated after DONE.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   ifill_req_*                  fill request (valid held until ack, way, paddr)
//   ifill_resp_valid_o           full line available (one-cycle pulse in DONE)
//   ifill_resp_ack_o             request accepted (one-cycle pulse, first REQ cycle)
//   ifill_resp_data_o            assembled line
//   ifill_resp_beat_o            beats received so far, saturates at N_BEAT-1
//   ifill_resp_inv_valid_o/paddr invalidation (forwarded or replayed) to icache
//   refill_way_o, busy_o         latched way, FSM not idle
//   mem_req_*                    line read request to memory
//   mem_resp_*                   return beats, address order
//   mem_inv_*                    external invalidation
module sargantana_icache_refill_unit #(
    parameter int PADDR_W = 40,
    parameter int LINE_W  = 256,
    parameter int BEAT_W  = 64,
    parameter int N_WAY   = 4,
    parameter int IDX_W   = 12
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       ifill_req_valid_i,
    input  logic [$clog2(N_WAY)-1:0]   ifill_req_way_i,
    input  logic [PADDR_W-1:0]         ifill_req_paddr_i,
    output logic                       ifill_resp_valid_o,
    output logic                       ifill_resp_ack_o,
    output logic [LINE_W-1:0]          ifill_resp_data_o,
    output logic [$clog2(LINE_W/BEAT_W)-1:0] ifill_resp_beat_o,
    output logic                       ifill_resp_inv_valid_o,
    output logic [IDX_W-1:0]           ifill_resp_inv_paddr_o,
    output logic [$clog2(N_WAY)-1:0]   refill_way_o,
    output logic                       busy_o,
    output logic                       mem_req_valid_o,
    input  logic                       mem_req_ready_i,
    output logic [PADDR_W-1:0]         mem_req_addr_o,
    input  logic                       mem_resp_valid_i,
    input  logic [BEAT_W-1:0]          mem_resp_data_i,
    input  logic                       mem_inv_valid_i,
    input  logic [PADDR_W-1:0]         mem_inv_paddr_i
);

    localparam int WAY_W  = $clog2(N_WAY);
    localparam int N_BEAT = LINE_W / BEAT_W;
    localparam int CNT_W  = $clog2(N_BEAT);
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam logic [PADDR_W-1:0] LINE_MASK = ~PADDR_W'((2 ** OFF_W) - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WAY_W-1:0]    way_q, way_d;
    logic [PADDR_W-1:0]  addr_q, addr_d;
    logic [LINE_W-1:0]   data_q, data_d;
    logic                ack_q, ack_d;
    logic                poison_q, poison_d;
    logic                pend_q, pend_d;
    logic [IDX_W-1:0]    ridx_q, ridx_d;
    logic                inv_valid_q, inv_valid_d;
    logic [IDX_W-1:0]    inv_paddr_q, inv_paddr_d;
    logic                line_hit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            way_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            ack_q       <= 1'b0;
            poison_q    <= 1'b0;
            pend_q      <= 1'b0;
            ridx_q      <= '0;
            inv_valid_q <= 1'b0;
            inv_paddr_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            way_q       <= way_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            ack_q       <= ack_d;
            poison_q    <= poison_d;
            pend_q      <= pend_d;
            ridx_q      <= ridx_d;
            inv_valid_q <= inv_valid_d;
            inv_paddr_q <= inv_paddr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        way_d       = way_q;
        addr_d      = addr_q;
        data_d      = data_q;
        ack_d       = 1'b0;
        poison_d    = poison_q;
        pend_d      = pend_q;
        ridx_d      = ridx_q;
        inv_valid_d = 1'b0;
        inv_paddr_d = inv_paddr_q;

        line_hit = mem_inv_valid_i &&
                   (mem_inv_paddr_i[PADDR_W-1:OFF_W] == addr_q[PADDR_W-1:OFF_W]);

        // External invalidations own the output slot; a pending replay only
        // goes out in a cycle with no external invalidation.
        if (mem_inv_valid_i) begin
            inv_valid_d = 1'b1;
            inv_paddr_d = mem_inv_paddr_i[IDX_W-1:0];
        end else if (pend_q) begin
            inv_valid_d = 1'b1;
            inv_paddr_d = ridx_q;
            pend_d      = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (ifill_req_valid_i) begin
                    state_d  = REQ;
                    way_d    = ifill_req_way_i;
                    addr_d   = ifill_req_paddr_i & LINE_MASK;
                    cnt_d    = '0;
                    poison_d = 1'b0;
                    ack_d    = 1'b1;
                end
            end
            REQ: begin
                if (line_hit) poison_d = 1'b1;
                if (mem_req_ready_i) state_d = FILL;
            end
            FILL: begin
                if (line_hit) poison_d = 1'b1;
                if (mem_resp_valid_i) begin
                    for (int b = 0; b < N_BEAT; b++) begin
                        if (cnt_q == CNT_W'(b)) data_d[b*BEAT_W +: BEAT_W] = mem_resp_data_i;
                    end
                    // The counter saturates on the last beat so beat_o reads
                    // N_BEAT-1 throughout DONE.
                    if (cnt_q == CNT_W'(N_BEAT - 1)) state_d = DONE;
                    else                             cnt_d   = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                // Arm the replay here so it competes for the output slot in
                // the cycle after DONE; the index is captured separately so a
                // new fill accepted in that cycle cannot change it.
                if (poison_q || line_hit) begin
                    pend_d = 1'b1;
                    ridx_d = addr_q[IDX_W-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ifill_resp_valid_o     = (state_q == DONE);
    assign ifill_resp_ack_o       = ack_q;
    assign ifill_resp_data_o      = data_q;
    assign ifill_resp_beat_o      = cnt_q;
    assign ifill_resp_inv_valid_o = inv_valid_q;
    assign ifill_resp_inv_paddr_o = inv_paddr_q;
    assign refill_way_o           = way_q;
    assign busy_o                 = (state_q != IDLE);
    assign mem_req_valid_o        = (state_q == REQ);
    assign mem_req_addr_o         = addr_q;

endmodule

// File: tb/tb_sargantana_icache_refill_unit.sv
// tb/tb_sargantana_icache_refill_unit.sv - self-checking bench for sargantana_icache_refill_unit
module tb_sargantana_icache_refill_unit;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          ifill_req_valid_i;
    logic [1:0]    ifill_req_way_i;
    logic [39:0]   ifill_req_paddr_i;
    logic          ifill_resp_valid_o;
    logic          ifill_resp_ack_o;
    logic [255:0]  ifill_resp_data_o;
    logic [1:0]    ifill_resp_beat_o;
    logic          ifill_resp_inv_valid_o;
    logic [11:0]   ifill_resp_inv_paddr_o;
    logic [1:0]    refill_way_o;
    logic          busy_o;
    logic          mem_req_valid_o;
    logic          mem_req_ready_i;
    logic [39:0]   mem_req_addr_o;
    logic          mem_resp_valid_i;
    logic [63:0]   mem_resp_data_i;
    logic          mem_inv_valid_i;
    logic [39:0]   mem_inv_paddr_i;

    sargantana_icache_refill_unit dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .ifill_req_valid_i      (ifill_req_valid_i),
        .ifill_req_way_i        (ifill_req_way_i),
        .ifill_req_paddr_i      (ifill_req_paddr_i),
        .ifill_resp_valid_o     (ifill_resp_valid_o),
        .ifill_resp_ack_o       (ifill_resp_ack_o),
        .ifill_resp_data_o      (ifill_resp_data_o),
        .ifill_resp_beat_o      (ifill_resp_beat_o),
        .ifill_resp_inv_valid_o (ifill_resp_inv_valid_o),
        .ifill_resp_inv_paddr_o (ifill_resp_inv_paddr_o),
        .refill_way_o           (refill_way_o),
        .busy_o                 (busy_o),
        .mem_req_valid_o        (mem_req_valid_o),
        .mem_req_ready_i        (mem_req_ready_i),
        .mem_req_addr_o         (mem_req_addr_o),
        .mem_resp_valid_i       (mem_resp_valid_i),
        .mem_resp_data_i        (mem_resp_data_i),
        .mem_inv_valid_i        (mem_inv_valid_i),
        .mem_inv_paddr_i        (mem_inv_paddr_i)
    );

    always #5 clk_i = ~clk_i;

    int          n_chk  = 0;
    int          n_pass = 0;
    bit          chk_on = 1'b0;
    int          inv_pct = 0;
    int          streak = 0;
    bit          poison;
    logic [39:0] cur_line;
    logic [63:0] beats [4];
    logic [11:0] replay_q [$];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive one cycle's invalidation input; a hit on the line being filled
    // while a fill is in flight (REQ/FILL/DONE) poisons that fill.
    task automatic drive_inv(input bit v, input logic [39:0] a, input bit window);
        mem_inv_valid_i = v;
        mem_inv_paddr_i = a;
        if (v && window && (a[39:5] == cur_line[39:5])) poison = 1'b1;
        streak = v ? streak + 1 : 0;
    endtask

    task automatic rand_inv(input bit window);
        logic [39:0] a;
        if (streak < 2 && int'($urandom_range(99)) < inv_pct) begin
            if ($urandom_range(1) == 1) a = {cur_line[39:5], 5'($urandom)};
            else                        a = {8'($urandom), 32'($urandom)};
            drive_inv(1'b1, a, window);
        end else begin
            drive_inv(1'b0, '0, window);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            rand_inv(1'b0);
            mem_resp_valid_i = 1'($urandom_range(1));
            mem_resp_data_i  = {$urandom, $urandom};
            #4;
            chk("idle_busy", busy_o, 0);
            chk("idle_req_valid", mem_req_valid_o, 0);
            chk("idle_resp_valid", ifill_resp_valid_o, 0);
            tick();
        end
        mem_resp_valid_i = 1'b0;
    endtask

    // One complete fill starting in an IDLE cycle; returns at the start of
    // the cycle after DONE.
    task automatic fill(input logic [39:0] paddr, input logic [1:0] way, input int rdly,
                        input int gap, input int pois_beat, input bit hold);
        logic [39:0]  line;
        logic [255:0] exp_line;
        line     = paddr & ~40'h1f;
        exp_line = {beats[3], beats[2], beats[1], beats[0]};
        cur_line = line;
        poison   = 1'b0;
        ifill_req_valid_i = 1'b1;
        ifill_req_way_i   = way;
        ifill_req_paddr_i = paddr;
        mem_resp_valid_i  = 1'b0;
        rand_inv(1'b0);
        #4;
        chk("accept_busy", busy_o, 0);
        chk("accept_req_valid", mem_req_valid_o, 0);
        tick();
        if (!hold) ifill_req_valid_i = 1'b0;
        for (int i = 0; i <= rdly; i++) begin
            mem_req_ready_i  = (i == rdly);
            mem_resp_valid_i = 1'($urandom_range(1));
            mem_resp_data_i  = {$urandom, $urandom};
            rand_inv(1'b1);
            #4;
            chk("ack", ifill_resp_ack_o, (i == 0));
            chk("req_valid", mem_req_valid_o, 1);
            chk("req_addr", mem_req_addr_o, line);
            chk("req_beat", ifill_resp_beat_o, 0);
            chk("req_busy", busy_o, 1);
            chk("req_way", refill_way_o, way);
            tick();
        end
        mem_req_ready_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gap; g++) begin
                mem_resp_valid_i = 1'b0;
                rand_inv(1'b1);
                #4;
                chk("gap_beat", ifill_resp_beat_o, b);
                chk("gap_req_valid", mem_req_valid_o, 0);
                chk("gap_resp_valid", ifill_resp_valid_o, 0);
                chk("gap_ack", ifill_resp_ack_o, 0);
                tick();
            end
            mem_resp_valid_i = 1'b1;
            mem_resp_data_i  = beats[b];
            if (b == pois_beat) drive_inv(1'b1, {line[39:5], 5'h07}, 1'b1);
            else                rand_inv(1'b1);
            #4;
            chk("fill_beat", ifill_resp_beat_o, b);
            chk("fill_resp_valid", ifill_resp_valid_o, 0);
            chk("fill_req_valid", mem_req_valid_o, 0);
            tick();
        end
        mem_resp_valid_i = 1'($urandom_range(1));
        mem_resp_data_i  = {$urandom, $urandom};
        rand_inv(1'b1);
        #4;
        chk("done_resp_valid", ifill_resp_valid_o, 1);
        chk("done_data", ifill_resp_data_o, exp_line);
        chk("done_beat", ifill_resp_beat_o, 3);
        chk("done_way", refill_way_o, way);
        chk("done_busy", busy_o, 1);
        chk("done_req_valid", mem_req_valid_o, 0);
        chk("done_ack", ifill_resp_ack_o, 0);
        if (hold) ifill_req_valid_i = 1'b0;
        tick();
        mem_resp_valid_i = 1'b0;
        if (poison) replay_q.push_back(line[11:0]);
    endtask

    // Invalidation reference: external invalidation wins the slot, otherwise
    // the oldest owed replay goes out; everything shows up one cycle later.
    initial begin
        bit          ev;
        logic [11:0] ea;
        ea = '0;
        forever begin
            @(posedge clk_i);
            if (rst_i) begin
                ev = 1'b0;
                replay_q.delete();
            end else if (mem_inv_valid_i) begin
                ev = 1'b1;
                ea = mem_inv_paddr_i[11:0];
            end else if (replay_q.size() > 0) begin
                ev = 1'b1;
                ea = replay_q.pop_front();
            end else begin
                ev = 1'b0;
            end
            @(negedge clk_i);
            if (rst_i) ev = 1'b0;
            if (chk_on) begin
                chk("inv_valid", ifill_resp_inv_valid_o, ev);
                if (ev) chk("inv_paddr", ifill_resp_inv_paddr_o, ea);
            end
        end
    end

    initial begin
        logic [39:0] line;
        rst_i = 1'b1;
        ifill_req_valid_i = 1'b0;
        ifill_req_way_i   = '0;
        ifill_req_paddr_i = '0;
        mem_req_ready_i   = 1'b0;
        mem_resp_valid_i  = 1'b0;
        mem_resp_data_i   = '0;
        mem_inv_valid_i   = 1'b0;
        mem_inv_paddr_i   = '0;
        cur_line = '0;
        #2;
        chk("rst_busy", busy_o, 0);
        chk("rst_data", ifill_resp_data_o, 0);
        chk("rst_beat", ifill_resp_beat_o, 0);
        chk("rst_way", refill_way_o, 0);
        chk("rst_addr", mem_req_addr_o, 0);
        chk("rst_ack", ifill_resp_ack_o, 0);
        chk("rst_inv", ifill_resp_inv_valid_o, 0);
        tick();
        rst_i  = 1'b0;
        chk_on = 1'b1;

        // basic fill, immediate ready, back-to-back beats
        beats[0] = 64'h1111_1111_1111_1111;
        beats[1] = 64'h2222_2222_2222_2222;
        beats[2] = 64'h3333_3333_3333_3333;
        beats[3] = 64'h4444_4444_4444_4444;
        fill(40'h00_8000_1234, 2'd2, 0, 0, -1, 1'b0);
        chk("basic_addr", mem_req_addr_o, 40'h00_8000_1220);

        // idle-time invalidation forwarding
        drive_inv(1'b1, 40'h00_8000_2FC0, 1'b0);
        #4;
        tick();
        drive_inv(1'b0, '0, 1'b0);
        #4;
        chk("fwd_valid", ifill_resp_inv_valid_o, 1);
        chk("fwd_paddr", ifill_resp_inv_paddr_o, 12'hFC0);
        tick();

        // backpressure and gaps
        for (int b = 0; b < 4; b++) beats[b] = {$urandom, $urandom};
        fill(40'h12_3456_789A, 2'd1, 3, 2, -1, 1'b0);

        // held request: one memory request only, then a fresh fill
        for (int b = 0; b < 4; b++) beats[b] = {$urandom, $urandom};
        fill(40'h00_0ABC_DE40, 2'd3, 1, 0, -1, 1'b1);
        idle(2);
        for (int b = 0; b < 4; b++) beats[b] = {$urandom, $urandom};
        fill(40'h00_0ABC_DE60, 2'd0, 0, 1, -1, 1'b0);

        // poisoned fill with a colliding external invalidation after DONE
        for (int b = 0; b < 4; b++) beats[b] = {$urandom, $urandom};
        line = 40'h00_9000_4560;
        fill(40'h00_9000_457C, 2'd1, 0, 0, 1, 1'b0);
        drive_inv(1'b1, 40'h12_3456_7678, 1'b0);
        #4;
        tick();
        drive_inv(1'b0, '0, 1'b0);
        #4;
        chk("poison_ext_valid", ifill_resp_inv_valid_o, 1);
        chk("poison_ext_paddr", ifill_resp_inv_paddr_o, 12'h678);
        tick();
        #4;
        chk("replay_valid", ifill_resp_inv_valid_o, 1);
        chk("replay_paddr", ifill_resp_inv_paddr_o, line[11:0]);
        tick();

        // reset mid-fill after two beats, then stray beats
        cur_line = 40'h00_7777_0000;
        ifill_req_valid_i = 1'b1;
        ifill_req_way_i   = 2'd3;
        ifill_req_paddr_i = 40'h00_7777_0008;
        tick();
        ifill_req_valid_i = 1'b0;
        mem_req_ready_i   = 1'b1;
        tick();
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 64'hDEAD_BEEF_0000_0001;
        tick();
        mem_resp_data_i  = 64'hDEAD_BEEF_0000_0002;
        tick();
        mem_resp_valid_i = 1'b0;
        rst_i = 1'b1;
        #1;
        chk("mrst_busy", busy_o, 0);
        chk("mrst_beat", ifill_resp_beat_o, 0);
        chk("mrst_data", ifill_resp_data_o, 0);
        chk("mrst_way", refill_way_o, 0);
        chk("mrst_addr", mem_req_addr_o, 0);
        chk("mrst_resp_valid", ifill_resp_valid_o, 0);
        tick();
        rst_i = 1'b0;
        for (int s = 0; s < 2; s++) begin
            mem_resp_valid_i = 1'b1;
            mem_resp_data_i  = {$urandom, $urandom};
            #4;
            chk("stray_busy", busy_o, 0);
            chk("stray_beat", ifill_resp_beat_o, 0);
            chk("stray_data", ifill_resp_data_o, 0);
            tick();
        end
        mem_resp_valid_i = 1'b0;
        for (int b = 0; b < 4; b++) beats[b] = {$urandom, $urandom};
        fill(40'h00_7777_0008, 2'd2, 0, 0, -1, 1'b0);

        // randomized fills with background invalidation traffic
        inv_pct = 25;
        for (int n = 0; n < 14; n++) begin
            for (int b = 0; b < 4; b++) beats[b] = {$urandom, $urandom};
            fill({8'($urandom), 32'($urandom)}, 2'($urandom), int'($urandom_range(3)),
                 int'($urandom_range(2)),
                 ($urandom_range(2) == 0) ? int'($urandom_range(3)) : -1,
                 1'($urandom_range(1)));
            idle(int'($urandom_range(2)));
        end
        inv_pct = 0;
        idle(4);
        chk("replay_drained", replay_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
